div_unit: RTL and testbench

- Multi-cycle integer divider serving the ALU's DIV/DIVU/REM/REMU path.
- The ALU drives start, dividend and divisor, and holds its stall (busy) while start is high.
- This block sequences a radix-2 restoring division over DATA_WIDTH iterations, then returns a one-cycle ready pulse with the result.
- Sits beside the ALU in the execute stage; also accepts a pipeline flush.

---
 rtl/div_unit.sv | 168 ++++++++++++++++
 tb/tb_div_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for the ALU DIV/DIVU/REM/REMU path.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | waiting for start; operands are latched on accept
//  CALC   | one quotient bit per cycle, DATA_WIDTH iterations
//  DONE   | result register valid, ready pulse asserted for one cycle
module div_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  div_start_i,
    input  logic [1:0]            div_op_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    input  logic                  flush_i,
    output logic                  div_res_ready_o,
    output logic [DATA_WIDTH-1:0] div_result_o,
    output logic                  div_busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    state_t state, state_nxt;

    logic [CNT_WIDTH-1:0]  cnt;
    logic                  rem_op_q;
    logic                  neg_quo_q;
    logic                  neg_rem_q;
    logic [DATA_WIDTH-1:0] dvs_q;
    logic [DATA_WIDTH-1:0] rem_q;
    logic [DATA_WIDTH-1:0] quo_q;
    logic [DATA_WIDTH-1:0] result_q;

    // op[0]=1 selects the unsigned variants, op[1]=1 selects the remainder
    logic                  is_signed;
    logic                  dvd_neg;
    logic                  dvs_neg;
    logic [DATA_WIDTH-1:0] dvd_mag;
    logic [DATA_WIDTH-1:0] dvs_mag;
    logic                  div_zero;
    logic                  ovf;
    logic                  special;
    logic [DATA_WIDTH-1:0] spec_res;
    logic                  accept;
    logic                  calc_step;
    logic                  last;

    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH:0]   diff;
    logic [DATA_WIDTH-1:0] rem_nxt;
    logic [DATA_WIDTH-1:0] quo_nxt;
    logic [DATA_WIDTH-1:0] quo_fin;
    logic [DATA_WIDTH-1:0] rem_fin;
    logic [DATA_WIDTH-1:0] fin_res;

    // Operand decode, magnitudes and special-case detection for the accept cycle
    always_comb begin
        is_signed = ~div_op_i[0];
        dvd_neg   = is_signed & dividend_i[DATA_WIDTH-1];
        dvs_neg   = is_signed & divisor_i[DATA_WIDTH-1];
        dvd_mag   = dvd_neg ? (~dividend_i + 1'b1) : dividend_i;
        dvs_mag   = dvs_neg ? (~divisor_i + 1'b1) : divisor_i;
        div_zero  = (divisor_i == '0);
        ovf       = is_signed && (dividend_i == MIN_NEG) && (divisor_i == '1);
        special   = div_zero | ovf;
        if (div_zero) begin
            spec_res = div_op_i[1] ? dividend_i : '1;
        end else begin
            spec_res = div_op_i[1] ? '0 : MIN_NEG;
        end
        accept    = (state == S_IDLE) && div_start_i && !flush_i;
        calc_step = (state == S_CALC) && div_start_i && !flush_i;
        last      = (cnt == CNT_LAST);
    end

    // One restoring iteration plus the sign correction used on the last one
    always_comb begin
        shifted = {rem_q, quo_q[DATA_WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        if (!diff[DATA_WIDTH]) begin
            rem_nxt = diff[DATA_WIDTH-1:0];
            quo_nxt = {quo_q[DATA_WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[DATA_WIDTH-1:0];
            quo_nxt = {quo_q[DATA_WIDTH-2:0], 1'b0};
        end
        quo_fin = neg_quo_q ? (~quo_nxt + 1'b1) : quo_nxt;
        rem_fin = neg_rem_q ? (~rem_nxt + 1'b1) : rem_nxt;
        fin_res = rem_op_q ? rem_fin : quo_fin;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush wins over everything, dropping start aborts CALC
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (div_start_i && !flush_i) begin
                    state_nxt = special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (flush_i || !div_start_i) begin
                    state_nxt = S_IDLE;
                end else if (last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch on accept, iterate in CALC, load result on DONE entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            rem_op_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            result_q  <= '0;
        end else if (accept) begin
            cnt       <= '0;
            rem_op_q  <= div_op_i[1];
            neg_quo_q <= dvd_neg ^ dvs_neg;
            neg_rem_q <= dvd_neg;
            dvs_q     <= dvs_mag;
            rem_q     <= '0;
            quo_q     <= dvd_mag;
            if (special) begin
                result_q <= spec_res;
            end
        end else if (calc_step) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt   <= cnt + 1'b1;
            if (last) begin
                result_q <= fin_res;
            end
        end
    end

    assign div_res_ready_o = (state == S_DONE);
    assign div_busy_o      = (state != S_IDLE);
    assign div_result_o    = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed table, random vs. arithmetic model,
// and hand-written flush / abort / reset / back-to-back sequences.
module tb_div_unit;

    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic          div_start_i;
    logic [1:0]    div_op_i;
    logic [W-1:0]  dividend_i;
    logic [W-1:0]  divisor_i;
    logic          flush_i;
    logic          div_res_ready_o;
    logic [W-1:0]  div_result_o;
    logic          div_busy_o;

    int checks;
    int failures;

    div_unit #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .div_start_i     (div_start_i),
        .div_op_i        (div_op_i),
        .dividend_i      (dividend_i),
        .divisor_i       (divisor_i),
        .flush_i         (flush_i),
        .div_res_ready_o (div_res_ready_o),
        .div_result_o    (div_result_o),
        .div_busy_o      (div_busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        int           lat;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference: plain language arithmetic with the two architected special cases
    task automatic ref_div(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] res, output int lat);
        logic signed [W-1:0] sa, sb;
        logic [W-1:0] q, r;
        bit sgn;
        sgn = (op[0] == 1'b0);
        sa = a;
        sb = b;
        lat = W + 1;
        if (b == 0) begin
            q = '1; r = a; lat = 1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 0; lat = 1;
        end else if (sgn) begin
            q = sa / sb; r = sa % sb;
        end else begin
            q = a / b; r = a % b;
        end
        res = op[1] ? r : q;
    endtask

    // Issue one operation with start held until ready; operands scrambled after accept
    task automatic do_div(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output int lat);
        lat = -1;
        res = '0;
        div_op_i    = op;
        dividend_i  = a;
        divisor_i   = b;
        div_start_i = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                div_op_i   = 2'($urandom_range(0, 3));
                dividend_i = $urandom;
                divisor_i  = $urandom;
            end
            if (div_res_ready_o) begin
                res = div_result_o;
                lat = k;
                break;
            end
        end
        div_start_i = 1'b0;
        if (lat > 0) begin
            @(posedge clk); #1;
            chk("ready_one_cycle", {31'b0, div_res_ready_o}, 32'd0);
        end
    endtask

    initial begin
        logic [W-1:0] res, exp, prev;
        int lat, elat, nrdy, rcyc[2];
        logic [W-1:0] rres[2];
        logic [1:0] op;
        logic [W-1:0] a, b;
        bit saw;

        checks = 0;
        failures = 0;

        vecs[0]  = '{2'b01, 32'd100,         32'd7,           32'd14,          33};
        vecs[1]  = '{2'b11, 32'd100,         32'd7,           32'd2,           33};
        vecs[2]  = '{2'b00, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD,   33};
        vecs[3]  = '{2'b10, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF,   33};
        vecs[4]  = '{2'b00, 32'd7,           32'hFFFF_FFFE,   32'hFFFF_FFFD,   33};
        vecs[5]  = '{2'b10, 32'd7,           32'hFFFF_FFFE,   32'd1,           33};
        vecs[6]  = '{2'b01, 32'd5,           32'd0,           32'hFFFF_FFFF,   1};
        vecs[7]  = '{2'b10, 32'hFFFF_FFF6,   32'd0,           32'hFFFF_FFF6,   1};
        vecs[8]  = '{2'b00, 32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   1};
        vecs[9]  = '{2'b10, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           1};
        vecs[10] = '{2'b01, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           33};

        rst_n = 1'b0;
        div_start_i = 1'b0;
        div_op_i = 2'b00;
        dividend_i = '0;
        divisor_i = '0;
        flush_i = 1'b0;
        #1;
        chk("reset_ready",  {31'b0, div_res_ready_o}, 32'd0);
        chk("reset_result", div_result_o, 32'd0);
        chk("reset_busy",   {31'b0, div_busy_o}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            do_div(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 0;
                1: begin b = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
                2: b = $urandom_range(1, 15);
                3: b = $urandom >> $urandom_range(1, 31);
                default: b = $urandom;
            endcase
            ref_div(op, a, b, exp, elat);
            do_div(op, a, b, res, lat);
            chk($sformatf("rnd%0d_op%0d_%h_%h", i, op, a, b), res, exp);
            chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(elat));
        end

        // Flush in cycle 10: no ready, result untouched, then a clean DIVU 9/3
        do_div(2'b01, 32'd100, 32'd7, prev, lat);
        chk("pre_flush_result", prev, 32'd14);
        div_op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd3; div_start_i = 1'b1;
        saw = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (div_res_ready_o) saw = 1;
        end
        flush_i = 1'b1;
        @(posedge clk); #1;
        chk("flush_no_ready_calc", {31'b0, saw}, 32'd0);
        chk("flush_busy",   {31'b0, div_busy_o}, 32'd0);
        chk("flush_ready",  {31'b0, div_res_ready_o}, 32'd0);
        chk("flush_result", div_result_o, prev);
        flush_i = 1'b0; div_start_i = 1'b0;
        @(posedge clk); #1;
        do_div(2'b01, 32'd9, 32'd3, res, lat);
        chk("post_flush_result", res, 32'd3);
        chk("post_flush_latency", 32'(lat), 32'd33);

        // Dropping start during CALC aborts without a ready pulse
        div_op_i = 2'b01; dividend_i = 32'd77; divisor_i = 32'd7; div_start_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin @(posedge clk); #1; end
        div_start_i = 1'b0;
        saw = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (div_res_ready_o || div_busy_o) saw = 1;
        end
        chk("abort_quiet", {31'b0, saw}, 32'd0);
        chk("abort_result", div_result_o, 32'd3);

        // Asynchronous reset in cycle 15 of an operation
        div_op_i = 2'b01; dividend_i = 32'd50; divisor_i = 32'd5; div_start_i = 1'b1;
        for (int k = 1; k <= 15; k++) begin @(posedge clk); #1; end
        chk("pre_reset_busy", {31'b0, div_busy_o}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_result", div_result_o, 32'd0);
        chk("midreset_ready",  {31'b0, div_res_ready_o}, 32'd0);
        chk("midreset_busy",   {31'b0, div_busy_o}, 32'd0);
        div_start_i = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back with start held: DIVU 20/4 then REMU 20/6
        div_op_i = 2'b01; dividend_i = 32'd20; divisor_i = 32'd4; div_start_i = 1'b1;
        nrdy = 0;
        rcyc[0] = 0; rcyc[1] = 0; rres[0] = '0; rres[1] = '0;
        for (int k = 1; k <= 90 && nrdy < 2; k++) begin
            @(posedge clk); #1;
            if (div_res_ready_o) begin
                rcyc[nrdy] = k;
                rres[nrdy] = div_result_o;
                nrdy++;
                div_op_i = 2'b11; dividend_i = 32'd20; divisor_i = 32'd6;
            end
        end
        div_start_i = 1'b0;
        chk("b2b_count",   32'(nrdy), 32'd2);
        chk("b2b_first",   rres[0], 32'd5);
        chk("b2b_second",  rres[1], 32'd2);
        chk("b2b_lat",     32'(rcyc[0]), 32'd33);
        chk("b2b_spacing", 32'(rcyc[1] - rcyc[0]), 32'd34);

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
